bcd_conv: RTL
=============

Name: bcd_conv

Overview:
Iterative binary-to-BCD converter that sits directly upstream of the 7-segment display driver. It takes a binary value from the CPU datapath and produces the packed 32-bit digit word on the driver's `in` bus, one nibble per digit with digit 0 in bits [3:0]. It also produces a significant-digit mask the driver uses for leading-zero blanking.
- Decimal mode: shift-and-add-3 (double-dabble), one bit per clock.
- Hex mode: binary passes straight through.

Parameters:
IN_W, 16, width of the binary input; must satisfy DIGITS*4 >= BCD width of (2^IN_W - 1).
DIGITS, 8, number of output digit nibbles; output width is 4*DIGITS.

Ports:
clkIn  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request conversion; sampled only when busy=0
mode  input  1  0 = decimal (BCD), 1 = hex passthrough; sampled with start
bin  input  IN_W  binary value; sampled with start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when out/sig are updated
out  output  4*DIGITS  packed digit word; holds last completed result
sig  output  DIGITS  bit i = 1 if digit i is at or below the most significant nonzero digit; bit 0 always 1

Behaviour:
- Reset (rst=1 at a clkIn edge):
  - state=IDLE, out=0, sig=1 (only bit 0 set), busy=0, done=0.
  - Working registers and iteration counter are cleared.
  - rst takes priority over every other input, including mid-conversion: the conversion is aborted and no done is issued.
- FSM states: IDLE, SHIFT, FINISH.
  - IDLE: if start=1 at edge E0, latch bin into the shift register, latch mode, clear the BCD accumulator and counter, set busy=1.
    - mode=0: next state SHIFT.
    - mode=1: next state FINISH.
  - SHIFT: each edge performs one iteration:
    - For every BCD nibble >= 5, add 3 to that nibble.
    - Then shift {accumulator, shift register} left by 1; the shift register MSB enters accumulator bit 0.
    - After exactly IN_W iterations, go to FINISH.
  - FINISH: one edge.
    - out <= accumulator (decimal) or zero-extended bin (hex).
    - sig <= computed mask.
    - done=1, busy=0, state=IDLE.
- Latency, start sampled at edge E0:
  - Decimal: out/sig update and done rises at edge E0+IN_W+1 (E0+17 for default).
  - Hex: at edge E0+1.
  - done is high for exactly one cycle.
- busy: high from edge E0 until the edge that asserts done, where it falls.
- Start during busy: ignored; bin/mode changes during busy have no effect.
- Start in the done cycle: accepted (state is IDLE); back-to-back conversions are allowed with no gap.
- out/sig are written only in FINISH, so the display never sees partial results.
- sig computation:
  - Find the highest index j with a nonzero nibble in the final word.
  - sig bits 0..j = 1, all others 0.
  - If the whole word is zero, sig = 1 (digit 0 shown as "0").
- Add-3 correction: applied per nibble on the pre-shift accumulator, in parallel for all DIGITS nibbles. Nibbles never exceed 9 in decimal mode.

Test Plan:
- Reset: assert rst for 2 cycles -> out=32'h0000_0000, sig=8'h01, busy=0, done=0; no done pulse afterwards.
- Decimal: bin=16'd1234, mode=0, start for 1 cycle -> busy for 17 cycles, done pulse at E0+17, out=32'h0000_1234, sig=8'h0F.
- Max value: bin=16'hFFFF, mode=0 -> out=32'h0006_5535, sig=8'h1F. Then bin=16'd0 -> out=32'h0000_0000, sig=8'h01.
- Hex: bin=16'hBEEF, mode=1 -> done at E0+1, out=32'h0000_BEEF, sig=8'h0F. Then bin=16'h000A, mode=1 -> out=32'h0000_000A, sig=8'h01.
- Handshake: start bin=16'd42; assert start with bin=16'd999 during busy -> ignored, result out=32'h0000_0042. Assert start with bin=16'd7 in the done cycle -> second conversion accepted, out=32'h0000_0007 at 17 edges later.
- Abort: start bin=16'd5000, assert rst at iteration 8 -> next cycle out=0, sig=8'h01, busy=0, no done. New start with bin=16'd5000 -> out=32'h0000_5000, sig=8'h0F.

Source files
------------

// File: rtl/bcd_conv_if.sv
// Request/result bundle between the CPU datapath and the binary-to-BCD converter.
// The master issues start/mode/bin and the slave returns busy/done plus the display word and its digit mask.
interface bcd_conv_if #(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned DIGITS = 8
);
    logic                  start;
    logic                  mode;
    logic [IN_W-1:0]       bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   out;
    logic [DIGITS-1:0]     sig;

    modport master (
        output start, mode, bin,
        input  busy, done, out, sig
    );

    modport slave (
        input  start, mode, bin,
        output busy, done, out, sig
    );
endinterface

// File: rtl/bcd_conv.sv
// Iterative binary-to-BCD converter (double-dabble, one bit per clock) with a hex passthrough mode.
// Produces the packed digit word and the significant-digit mask used for leading-zero blanking.
module bcd_conv #(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned DIGITS = 8
) (
    input  logic       clkIn,
    input  logic       rst,
    bcd_conv_if.slave  bus
);
    localparam int unsigned OUT_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [OUT_W-1:0]    acc;
    logic [IN_W-1:0]     sr;
    logic                mode_q;
    logic [CNT_W-1:0]    cnt;
    logic [OUT_W-1:0]    out_q;
    logic [DIGITS-1:0]   sig_q;
    logic                busy_q;
    logic                done_q;

    logic                load_c;
    logic                shift_c;
    logic                fin_c;
    logic [OUT_W-1:0]    adj_c;
    logic [OUT_W-1:0]    res_c;
    logic [DIGITS-1:0]   sig_c;

    // State register
    always_ff @(posedge clkIn) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = bus.mode ? FINISH : SHIFT;
            SHIFT:   if (cnt == LAST_ITER) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        load_c  = 1'b0;
        shift_c = 1'b0;
        fin_c   = 1'b0;
        case (state)
            IDLE:    load_c  = bus.start;
            SHIFT:   shift_c = 1'b1;
            FINISH:  fin_c   = 1'b1;
            default: ;
        endcase
    end

    // Add-3 correction on every nibble of the pre-shift accumulator
    always_comb begin
        adj_c = acc;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Final word; the shift register still holds bin untouched in hex mode
    always_comb begin
        res_c = mode_q ? OUT_W'(sr) : acc;
    end

    // Mask covers every digit at or below the most significant nonzero one
    always_comb begin
        logic any;
        any   = 1'b0;
        sig_c = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            any      = any | (|res_c[4*i +: 4]);
            sig_c[i] = any;
        end
        sig_c[0] = 1'b1;
    end

    // Datapath and registered outputs
    always_ff @(posedge clkIn) begin
        if (rst) begin
            acc    <= '0;
            sr     <= '0;
            mode_q <= 1'b0;
            cnt    <= '0;
            out_q  <= '0;
            sig_q  <= DIGITS'(1);
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= fin_c;
            if (load_c) begin
                sr     <= bus.bin;
                mode_q <= bus.mode;
                acc    <= '0;
                cnt    <= '0;
                busy_q <= 1'b1;
            end
            if (shift_c) begin
                {acc, sr} <= {adj_c[OUT_W-2:0], sr, 1'b0};
                cnt       <= cnt + CNT_W'(1);
            end
            if (fin_c) begin
                out_q  <= res_c;
                sig_q  <= sig_c;
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.out  = out_q;
    assign bus.sig  = sig_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
